life_next_gen_engine: RTL and testbench

//  Computes the next Game-of-Life generation of the 1280x720 grid, one row per cycle, ahead of pixel_generator.

---
 rtl/life_pkg.sv | 17 +
 rtl/life_row_rule.sv | 33 +++
 rtl/life_next_gen_engine.sv | 156 +++++++++++++++
 tb/tb_life_next_gen_engine.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// Shared constants and FSM encoding for the Game-of-Life generation engine.
// The display stage always scans bank buf_sel; the engine writes the next generation into bank ~buf_sel.
package life_pkg;

  localparam int X_SIZE = 1280;
  localparam int Y_SIZE = 720;
  localparam int ROW_AW = 10;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    PRIME,
    RUN,
    DONE
  } life_state_e;

endpackage

// File: rtl/life_row_rule.sv
// Combinational Game-of-Life rule for one row, given the rows above (prev) and below (nxt).
// Columns beyond the row edges are dead unless WRAP folds them onto the opposite edge.
module life_row_rule #(
  parameter int X_SIZE = 1280,
  parameter int WRAP   = 0
) (
  input  logic [X_SIZE-1:0] prev,
  input  logic [X_SIZE-1:0] cur,
  input  logic [X_SIZE-1:0] nxt,
  output logic [X_SIZE-1:0] next_row
);

  for (genvar c = 0; c < X_SIZE; c++) begin : g_col
    localparam int L = (c == 0) ? X_SIZE - 1 : c - 1;
    localparam int R = (c == X_SIZE - 1) ? 0 : c + 1;
    localparam bit L_LIVE = (c != 0) || (WRAP != 0);
    localparam bit R_LIVE = (c != X_SIZE - 1) || (WRAP != 0);

    logic [3:0] n_left;
    logic [3:0] n_mid;
    logic [3:0] n_right;
    logic [3:0] n;

    // The cell itself (cur[c]) is excluded from the neighbour count.
    assign n_left  = L_LIVE ? (4'(prev[L]) + 4'(cur[L]) + 4'(nxt[L])) : 4'd0;
    assign n_mid   = 4'(prev[c]) + 4'(nxt[c]);
    assign n_right = R_LIVE ? (4'(prev[R]) + 4'(cur[R]) + 4'(nxt[R])) : 4'd0;
    assign n       = n_left + n_mid + n_right;

    assign next_row[c] = (n == 4'd3) | (cur[c] & (n == 4'd2));
  end

endmodule

// File: rtl/life_next_gen_engine.sv
// Computes one Game-of-Life generation per start, one row per cycle, through a prev/cur/nxt row window.
// Reads bank buf_sel, writes bank ~buf_sel, then flips buf_sel so display only ever sees a finished generation.
module life_next_gen_engine #(
  parameter int X_SIZE = life_pkg::X_SIZE,
  parameter int Y_SIZE = life_pkg::Y_SIZE,
  parameter int ROW_AW = life_pkg::ROW_AW,
  parameter int WRAP   = 0
) (
  input  logic              s_axi_lite_aclk,
  input  logic              axi_resetn,
  input  logic              start,
  input  logic              pause,
  output logic              rd_en,
  output logic [ROW_AW-1:0] rd_addr,
  input  logic [X_SIZE-1:0] rd_data,
  output logic              wr_en,
  output logic [ROW_AW-1:0] wr_addr,
  output logic [X_SIZE-1:0] wr_data,
  output logic              buf_sel,
  output logic              busy,
  output logic              done,
  output logic [15:0]       gen_count
);

  import life_pkg::*;

  localparam logic [ROW_AW-1:0] LAST_ROW   = ROW_AW'(Y_SIZE - 1);
  localparam logic [ROW_AW:0]   READ_LIMIT = (ROW_AW + 1)'(Y_SIZE - 1);

  life_state_e       state_q, state_d;
  logic [ROW_AW-1:0] r_q, r_d;
  logic [X_SIZE-1:0] prev_q, prev_d;
  logic [X_SIZE-1:0] cur_q, cur_d;
  logic [X_SIZE-1:0] first_q, first_d;
  logic              buf_sel_q, buf_sel_d;
  logic [15:0]       gen_count_q, gen_count_d;

  logic [X_SIZE-1:0] nxt;
  logic [X_SIZE-1:0] rule_row;
  logic [ROW_AW:0]   rd_ahead;

  // Past the last row there is no read in flight, so the row below comes from the edge policy.
  assign nxt      = (r_q == LAST_ROW) ? ((WRAP != 0) ? first_q : '0) : rd_data;
  assign rd_ahead = {1'b0, r_q} + (ROW_AW + 1)'(2);

  life_row_rule #(
    .X_SIZE (X_SIZE),
    .WRAP   (WRAP)
  ) u_rule (
    .prev     (prev_q),
    .cur      (cur_q),
    .nxt      (nxt),
    .next_row (rule_row)
  );

  always_ff @(posedge s_axi_lite_aclk or posedge axi_resetn) begin
    if (axi_resetn) begin
      state_q     <= IDLE;
      r_q         <= '0;
      prev_q      <= '0;
      cur_q       <= '0;
      first_q     <= '0;
      buf_sel_q   <= 1'b0;
      gen_count_q <= '0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      prev_q      <= prev_d;
      cur_q       <= cur_d;
      first_q     <= first_d;
      buf_sel_q   <= buf_sel_d;
      gen_count_q <= gen_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    prev_d      = prev_q;
    cur_d       = cur_q;
    first_d     = first_q;
    buf_sel_d   = buf_sel_q;
    gen_count_d = gen_count_q;
    rd_en       = 1'b0;
    rd_addr     = '0;
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    busy        = 1'b0;
    done        = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !pause) begin
          rd_en = 1'b1;
          busy  = 1'b1;
          if (WRAP != 0) begin
            rd_addr = LAST_ROW;
            state_d = PRE;
          end else begin
            rd_addr = '0;
            state_d = PRIME;
          end
        end
      end
      PRE: begin
        busy    = 1'b1;
        rd_en   = 1'b1;
        rd_addr = '0;
        prev_d  = rd_data;
        state_d = PRIME;
      end
      PRIME: begin
        busy    = 1'b1;
        rd_en   = 1'b1;
        rd_addr = ROW_AW'(1);
        cur_d   = rd_data;
        first_d = rd_data;
        if (WRAP == 0) begin
          prev_d = '0;
        end
        r_d     = '0;
        state_d = RUN;
      end
      RUN: begin
        busy    = 1'b1;
        wr_en   = 1'b1;
        wr_addr = r_q;
        wr_data = rule_row;
        prev_d  = cur_q;
        cur_d   = nxt;
        if (rd_ahead <= READ_LIMIT) begin
          rd_en   = 1'b1;
          rd_addr = rd_ahead[ROW_AW-1:0];
        end
        if (r_q == LAST_ROW) begin
          state_d = DONE;
        end else begin
          r_d = r_q + ROW_AW'(1);
        end
      end
      DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        buf_sel_d   = ~buf_sel_q;
        gen_count_d = gen_count_q + 16'd1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign buf_sel   = buf_sel_q;
  assign gen_count = gen_count_q;

endmodule

// File: tb/tb_life_next_gen_engine.sv
// Directed bench for life_next_gen_engine on a 16x8 grid: one instance with dead edges, one toroidal,
// each backed by a two-bank row RAM model with a 1-cycle read latency.
module tb_life_next_gen_engine;

  localparam int XS = 16;
  localparam int YS = 8;
  localparam int AW = 3;

  logic clk;
  logic reset;
  logic start_a, start_b, pause;

  logic          a_rd_en, a_wr_en, a_buf_sel, a_busy, a_done;
  logic [AW-1:0] a_rd_addr, a_wr_addr;
  logic [XS-1:0] a_rd_data, a_wr_data;
  logic [15:0]   a_gen_count;

  logic          b_rd_en, b_wr_en, b_buf_sel, b_busy, b_done;
  logic [AW-1:0] b_rd_addr, b_wr_addr;
  logic [XS-1:0] b_rd_data, b_wr_data;
  logic [15:0]   b_gen_count;

  logic [XS-1:0] mem_a [2][YS];
  logic [XS-1:0] mem_b [2][YS];
  logic [XS-1:0] grid  [YS];
  logic          ld_a, ld_b, ld_bank;

  int checks = 0;
  int errors = 0;
  int lat;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  life_next_gen_engine #(.X_SIZE(XS), .Y_SIZE(YS), .ROW_AW(AW), .WRAP(0)) dut_a (
    .s_axi_lite_aclk (clk),
    .axi_resetn      (reset),
    .start           (start_a),
    .pause           (pause),
    .rd_en           (a_rd_en),
    .rd_addr         (a_rd_addr),
    .rd_data         (a_rd_data),
    .wr_en           (a_wr_en),
    .wr_addr         (a_wr_addr),
    .wr_data         (a_wr_data),
    .buf_sel         (a_buf_sel),
    .busy            (a_busy),
    .done            (a_done),
    .gen_count       (a_gen_count)
  );

  life_next_gen_engine #(.X_SIZE(XS), .Y_SIZE(YS), .ROW_AW(AW), .WRAP(1)) dut_b (
    .s_axi_lite_aclk (clk),
    .axi_resetn      (reset),
    .start           (start_b),
    .pause           (pause),
    .rd_en           (b_rd_en),
    .rd_addr         (b_rd_addr),
    .rd_data         (b_rd_data),
    .wr_en           (b_wr_en),
    .wr_addr         (b_wr_addr),
    .wr_data         (b_wr_data),
    .buf_sel         (b_buf_sel),
    .busy            (b_busy),
    .done            (b_done),
    .gen_count       (b_gen_count)
  );

  // Grid RAM models: bench loads a whole bank in one cycle; engine reads buf_sel and writes ~buf_sel.
  always @(posedge clk) begin
    if (ld_a) begin
      for (int i = 0; i < YS; i++) mem_a[ld_bank][i] <= grid[i];
    end else if (a_wr_en) begin
      mem_a[~a_buf_sel][a_wr_addr] <= a_wr_data;
    end
    if (a_rd_en) a_rd_data <= mem_a[a_buf_sel][a_rd_addr];
  end

  always @(posedge clk) begin
    if (ld_b) begin
      for (int i = 0; i < YS; i++) mem_b[ld_bank][i] <= grid[i];
    end else if (b_wr_en) begin
      mem_b[~b_buf_sel][b_wr_addr] <= b_wr_data;
    end
    if (b_rd_en) b_rd_data <= mem_b[b_buf_sel][b_rd_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Loads grid into the chosen bank, pulses start, and returns the number of cycles until done.
  task automatic applyStimulus(input bit use_b, input bit bank, output int cycles);
    @(negedge clk);
    ld_bank = bank;
    if (use_b) ld_b = 1'b1; else ld_a = 1'b1;
    @(negedge clk);
    ld_a = 1'b0;
    ld_b = 1'b0;
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    cycles = 1;
    while (!(use_b ? b_done : a_done) && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  initial begin
    reset   = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    pause   = 1'b0;
    ld_a    = 1'b0;
    ld_b    = 1'b0;
    ld_bank = 1'b0;
    for (int i = 0; i < YS; i++) grid[i] = '0;

    repeat (2) @(negedge clk);
    checkOutput("reset_rd_en", a_rd_en, 0);
    checkOutput("reset_wr_en", a_wr_en, 0);
    checkOutput("reset_busy", a_busy, 0);
    checkOutput("reset_done", a_done, 0);
    checkOutput("reset_buf_sel", a_buf_sel, 0);
    checkOutput("reset_gen_count", a_gen_count, 0);
    checkOutput("reset_rd_addr", a_rd_addr, 0);
    checkOutput("reset_wr_data", a_wr_data, 0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] blinker, dead edges");
    for (int i = 0; i < YS; i++) grid[i] = '0;
    for (int i = 3; i <= 5; i++) grid[i] = 16'h0080;
    applyStimulus(1'b0, 1'b0, lat);
    checkOutput("blinker_latency", lat, 10);
    @(negedge clk);
    checkOutput("blinker_busy_after", a_busy, 0);
    checkOutput("blinker_buf_sel", a_buf_sel, 1);
    checkOutput("blinker_row2", mem_a[1][2], 16'h0000);
    checkOutput("blinker_row3", mem_a[1][3], 16'h0000);
    checkOutput("blinker_row4", mem_a[1][4], 16'h01C0);
    checkOutput("blinker_row5", mem_a[1][5], 16'h0000);
    for (int i = 0; i < YS; i++) grid[i] = mem_a[1][i];
    applyStimulus(1'b0, 1'b1, lat);
    checkOutput("blinker2_latency", lat, 10);
    @(negedge clk);
    checkOutput("blinker2_buf_sel", a_buf_sel, 0);
    checkOutput("blinker2_gen_count", a_gen_count, 2);
    checkOutput("blinker2_row2", mem_a[0][2], 16'h0000);
    checkOutput("blinker2_row3", mem_a[0][3], 16'h0080);
    checkOutput("blinker2_row4", mem_a[0][4], 16'h0080);
    checkOutput("blinker2_row5", mem_a[0][5], 16'h0080);

    $display("[TB] block still life, dead edges");
    for (int i = 0; i < YS; i++) grid[i] = '0;
    grid[0] = 16'h0006;
    grid[1] = 16'h0006;
    applyStimulus(1'b0, 1'b0, lat);
    @(negedge clk);
    for (int i = 0; i < YS; i++)
      checkOutput($sformatf("block_row%0d", i), mem_a[1][i], (i < 2) ? 16'h0006 : 16'h0000);

    $display("[TB] edge kill");
    for (int i = 0; i < YS; i++) grid[i] = '0;
    grid[0] = 16'h8001;
    applyStimulus(1'b0, 1'b1, lat);
    @(negedge clk);
    checkOutput("edge_row0", mem_a[0][0], 16'h0000);
    checkOutput("edge_row1", mem_a[0][1], 16'h0000);
    checkOutput("edge_gen_count", a_gen_count, 4);

    $display("[TB] start held for 20 cycles");
    start_a = 1'b1;
    repeat (20) @(negedge clk);
    start_a = 1'b0;
    repeat (15) @(negedge clk);
    checkOutput("hold_gen_count", a_gen_count, 6);
    checkOutput("hold_buf_sel", a_buf_sel, 0);
    checkOutput("hold_busy", a_busy, 0);

    $display("[TB] start while paused");
    pause   = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    checkOutput("paused_rd_en", a_rd_en, 0);
    checkOutput("paused_busy", a_busy, 0);
    repeat (5) @(negedge clk);
    start_a = 1'b0;
    pause   = 1'b0;
    checkOutput("paused_gen_count", a_gen_count, 6);

    $display("[TB] pause raised mid-generation");
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("pause_mid_wr_addr", a_wr_addr, 3);
    pause = 1'b1;
    lat = 0;
    while (!a_done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("pause_mid_done", a_done, 1);
    @(negedge clk);
    checkOutput("pause_mid_gen_count", a_gen_count, 7);
    pause = 1'b0;

    $display("[TB] reset mid-generation");
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("pre_reset_wr_en", a_wr_en, 1);
    checkOutput("pre_reset_wr_addr", a_wr_addr, 4);
    checkOutput("pre_reset_buf_sel", a_buf_sel, 1);
    reset = 1'b1;
    #1;
    checkOutput("mid_reset_wr_en", a_wr_en, 0);
    checkOutput("mid_reset_busy", a_busy, 0);
    checkOutput("mid_reset_buf_sel", a_buf_sel, 0);
    checkOutput("mid_reset_gen_count", a_gen_count, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < YS; i++) grid[i] = '0;
    for (int i = 3; i <= 5; i++) grid[i] = 16'h0080;
    applyStimulus(1'b0, 1'b0, lat);
    checkOutput("post_reset_latency", lat, 10);
    @(negedge clk);
    checkOutput("post_reset_row4", mem_a[1][4], 16'h01C0);
    checkOutput("post_reset_gen_count", a_gen_count, 1);

    $display("[TB] toroidal block across corners");
    for (int i = 0; i < YS; i++) grid[i] = '0;
    grid[0] = 16'h8001;
    grid[7] = 16'h8001;
    applyStimulus(1'b1, 1'b0, lat);
    checkOutput("wrap_block_latency", lat, 11);
    @(negedge clk);
    for (int i = 0; i < YS; i++)
      checkOutput($sformatf("wrap_block_row%0d", i), mem_b[1][i],
                  (i == 0 || i == 7) ? 16'h8001 : 16'h0000);

    $display("[TB] toroidal blinker on column 0");
    for (int i = 0; i < YS; i++) grid[i] = '0;
    for (int i = 0; i <= 2; i++) grid[i] = 16'h0001;
    applyStimulus(1'b1, 1'b1, lat);
    checkOutput("wrap_blinker_latency", lat, 11);
    @(negedge clk);
    checkOutput("wrap_blinker_row0", mem_b[0][0], 16'h0000);
    checkOutput("wrap_blinker_row1", mem_b[0][1], 16'h8003);
    checkOutput("wrap_blinker_row2", mem_b[0][2], 16'h0000);
    checkOutput("wrap_blinker_row7", mem_b[0][7], 16'h0000);
    checkOutput("wrap_gen_count", b_gen_count, 2);
    checkOutput("wrap_buf_sel", b_buf_sel, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
